// File: rtl/pe_feeder.sv
// Sequencer that streams weights, then activations, from the global buffer into a PE.
// It then steps the PE through its output rows and collects one partial sum per row.
module pe_feeder #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int GLB_ADDR_BITWIDTH = 10,
  parameter int W_BASE            = 0,
  parameter int A_BASE            = 16,
  parameter int kernel_size       = 3,
  parameter int act_size          = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  output logic                         busy,
  output logic                         done,
  output logic                         glb_rden,
  output logic [GLB_ADDR_BITWIDTH-1:0] glb_raddr,
  input  logic [DATA_BITWIDTH-1:0]     glb_rdata,
  output logic [DATA_BITWIDTH-1:0]     filt_out,
  output logic [DATA_BITWIDTH-1:0]     act_out,
  output logic                         load_en_wght,
  output logic                         load_en_act,
  output logic                         pe_start,
  input  logic                         load_done,
  input  logic                         compute_done,
  input  logic [DATA_BITWIDTH-1:0]     pe_out,
  output logic                         result_valid,
  output logic [DATA_BITWIDTH-1:0]     result_data,
  output logic [7:0]                   result_idx
);

  localparam int NW = kernel_size * kernel_size;
  localparam int NA = act_size * act_size;
  localparam int NR = act_size - kernel_size + 1;

  localparam logic [15:0] W_LAST = 16'(NW - 1);
  localparam logic [15:0] A_LAST = 16'(NA - 1);
  localparam logic [7:0]  R_LAST = 8'(NR - 1);

  localparam logic [GLB_ADDR_BITWIDTH-1:0] W_ADDR = GLB_ADDR_BITWIDTH'(W_BASE);
  localparam logic [GLB_ADDR_BITWIDTH-1:0] A_ADDR = GLB_ADDR_BITWIDTH'(A_BASE);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_W = 4'd1,
    WAIT_W = 4'd2,
    LOAD_A = 4'd3,
    WAIT_A = 4'd4,
    START  = 4'd5,
    WAIT_C = 4'd6,
    REWIND = 4'd7,
    FIN    = 4'd8
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0]              word_cnt;
  logic [15:0]              word_last;
  logic [7:0]               row_cnt;
  logic                     w_vld;
  logic                     w_first;
  logic                     a_vld;
  logic                     a_first;
  logic [DATA_BITWIDTH-1:0] filt_hold;
  logic [DATA_BITWIDTH-1:0] act_hold;
  logic [DATA_BITWIDTH-1:0] res_cap;
  logic                     res_pend;
  logic                     capture;

  // All PE-side strobes are single-cycle pulses with no back-pressure;
  // glb_rdata is trusted exactly one cycle after glb_rden, nothing else.
  assign word_last = (state == LOAD_W) ? W_LAST : A_LAST;
  assign capture   = (state == WAIT_C) && !res_pend && compute_done;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (go) state_nxt = LOAD_W;
      LOAD_W: if (word_cnt == W_LAST) state_nxt = WAIT_W;
      WAIT_W: if (load_done) state_nxt = LOAD_A;
      LOAD_A: if (word_cnt == A_LAST) state_nxt = WAIT_A;
      WAIT_A: if (load_done) state_nxt = START;
      START:  state_nxt = WAIT_C;
      // The result cycle is spent in WAIT_C so result_valid never meets pe_start.
      WAIT_C: if (res_pend) state_nxt = (row_cnt >= R_LAST) ? REWIND : START;
      REWIND: state_nxt = FIN;
      FIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      row_cnt   <= '0;
      w_vld     <= 1'b0;
      w_first   <= 1'b0;
      a_vld     <= 1'b0;
      a_first   <= 1'b0;
      filt_hold <= '0;
      act_hold  <= '0;
      res_cap   <= '0;
      res_pend  <= 1'b0;
    end else begin
      state   <= state_nxt;
      w_vld   <= (state == LOAD_W);
      w_first <= (state == LOAD_W) && (word_cnt == 16'd0);
      a_vld   <= (state == LOAD_A);
      a_first <= (state == LOAD_A) && (word_cnt == 16'd0);

      if (w_vld) filt_hold <= glb_rdata;
      if (a_vld) act_hold  <= glb_rdata;

      if ((state == LOAD_W) || (state == LOAD_A)) begin
        word_cnt <= (word_cnt == word_last) ? 16'd0 : word_cnt + 16'd1;
      end

      res_pend <= capture;
      if (capture) res_cap <= pe_out;

      if (res_pend) begin
        row_cnt <= row_cnt + 8'd1;
      end else if (state == FIN) begin
        row_cnt <= '0;
      end
    end
  end

  assign busy         = (state != IDLE);
  assign done         = (state == FIN);
  assign glb_rden     = (state == LOAD_W) || (state == LOAD_A);
  assign glb_raddr    = (state == LOAD_W) ? W_ADDR + GLB_ADDR_BITWIDTH'(word_cnt) :
                        (state == LOAD_A) ? A_ADDR + GLB_ADDR_BITWIDTH'(word_cnt) : '0;
  // Returned words pass straight through, then the last one is held.
  assign filt_out     = w_vld ? glb_rdata : filt_hold;
  assign act_out      = a_vld ? glb_rdata : act_hold;
  assign load_en_wght = w_first;
  assign load_en_act  = a_first;
  assign pe_start     = (state == START) || (state == REWIND);
  assign result_valid = res_pend;
  assign result_data  = res_cap;
  assign result_idx   = row_cnt;

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: global-buffer model, reactive PE stub, scenario tasks.
module tb_pe_feeder;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int WB = 0;
  localparam int AB = 16;
  localparam int K  = 3;
  localparam int A  = 5;
  localparam int NW = K * K;
  localparam int NA = A * A;
  localparam int NR = A - K + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          busy, done, glb_rden;
  logic [AW-1:0] glb_raddr;
  logic [DW-1:0] glb_rdata = '0;
  logic [DW-1:0] filt_out, act_out;
  logic          load_en_wght, load_en_act, pe_start;
  logic          load_done;
  logic          compute_done = 1'b0;
  logic [DW-1:0] pe_out = '0;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic [7:0]    result_idx;

  logic          stub_ld = 1'b0;
  logic          spur_ld = 1'b0;
  int            ld_cnt = 0;
  int            cd_cnt = 0;
  int            stub_row = 0;
  logic [DW-1:0] mem [0:1023];

  int vecs = 0;
  int errs = 0;

  logic [23:0]   exp_q[$];
  logic [DW-1:0] exp_w_q[$];
  logic [DW-1:0] exp_a_q[$];
  logic [AW-1:0] exp_addr_q[$];

  assign load_done = stub_ld | spur_ld;

  pe_feeder #(
    .DATA_BITWIDTH(DW), .GLB_ADDR_BITWIDTH(AW), .W_BASE(WB), .A_BASE(AB),
    .kernel_size(K), .act_size(A)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done),
    .glb_rden(glb_rden), .glb_raddr(glb_raddr), .glb_rdata(glb_rdata),
    .filt_out(filt_out), .act_out(act_out),
    .load_en_wght(load_en_wght), .load_en_act(load_en_act), .pe_start(pe_start),
    .load_done(load_done), .compute_done(compute_done), .pe_out(pe_out),
    .result_valid(result_valid), .result_data(result_data), .result_idx(result_idx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- global buffer model ----------------
  always @(posedge clk) begin
    if (glb_rden) glb_rdata <= mem[glb_raddr];
  end

  // ---------------- PE stub ----------------
  // load_done 3 cycles after the last loaded word; compute_done 5 cycles after pe_start.
  always @(posedge clk) begin
    if (reset) begin
      ld_cnt <= 0; stub_ld <= 1'b0; cd_cnt <= 0; compute_done <= 1'b0;
      stub_row <= 0; pe_out <= '0;
    end else begin
      stub_ld <= (ld_cnt == 1);
      if (load_en_wght) ld_cnt <= NW + 1;
      else if (load_en_act) ld_cnt <= NA + 1;
      else if (ld_cnt != 0) ld_cnt <= ld_cnt - 1;

      compute_done <= (cd_cnt == 1);
      if (pe_start) begin
        if (stub_row < NR) begin
          cd_cnt <= 4; pe_out <= DW'(200 + stub_row); stub_row <= stub_row + 1;
        end else begin
          cd_cnt <= 0; stub_row <= 0;
        end
      end else if (cd_cnt != 0) begin
        cd_cnt <= cd_cnt - 1;
      end
    end
  end

  // ---------------- driver / scenario tasks ----------------
  task automatic push_results();
    exp_q.delete();
    for (int r = 0; r < NR; r++) exp_q.push_back({8'(r), 16'(200 + r)});
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({busy, done, glb_rden, load_en_wght, load_en_act, pe_start, result_valid} !== 7'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {busy, done, glb_rden, load_en_wght, load_en_act, pe_start, result_valid});
    end
    vecs++;
    if (glb_raddr !== '0) begin errs++; $display("FAIL reset_raddr: got %0d expected 0", glb_raddr); end
    vecs++;
    if (filt_out !== '0 || act_out !== '0) begin
      errs++; $display("FAIL reset_streams: got filt %0d act %0d expected 0 0", filt_out, act_out);
    end
    vecs++;
    if (result_data !== '0 || result_idx !== '0) begin
      errs++; $display("FAIL reset_result: got data %0d idx %0d expected 0 0", result_data, result_idx);
    end
    reset = 1'b0; go = 1'b0;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || glb_rden !== 1'b0) begin
      errs++; $display("FAIL reset_release_idle: got busy %b rden %b expected 0 0", busy, glb_rden);
    end
  endtask

  task automatic test_full_job();
    int w_first = 0, a_first = 0, n_lw = 0, n_la = 0, n_start = 0, n_done = 0, n_ovl = 0;
    bit fin = 1'b0;
    logic [23:0]   e;
    logic [DW-1:0] ew;
    logic [AW-1:0] ea;
    exp_w_q.delete(); exp_a_q.delete(); exp_addr_q.delete();
    for (int i = 0; i < NW; i++) begin exp_w_q.push_back(DW'(i + 1)); exp_addr_q.push_back(AW'(WB + i)); end
    for (int i = 0; i < NA; i++) begin exp_a_q.push_back(DW'(101 + i)); exp_addr_q.push_back(AW'(AB + i)); end
    push_results();
    go = 1'b1; @(negedge clk); go = 1'b0;
    for (int k = 1; k <= 400 && !fin; k++) begin
      if (k == 1) begin
        vecs++;
        if (glb_rden !== 1'b1 || busy !== 1'b1 || glb_raddr !== AW'(WB)) begin
          errs++; $display("FAIL first_read: got rden %b busy %b addr %0d expected 1 1 %0d",
            glb_rden, busy, glb_raddr, WB);
        end
      end
      if (glb_rden) begin
        ea = exp_addr_q.size() ? exp_addr_q.pop_front() : 'x;
        vecs++;
        if (glb_raddr !== ea) begin errs++; $display("FAIL read_addr: got %0d expected %0d", glb_raddr, ea); end
      end
      if (load_en_wght) begin n_lw++; if (w_first == 0) w_first = k; end
      if (load_en_act)  begin n_la++; if (a_first == 0) a_first = k; end
      if (k >= 2 && k < 2 + NW) begin
        ew = exp_w_q.size() ? exp_w_q.pop_front() : 'x;
        vecs++;
        if (filt_out !== ew) begin errs++; $display("FAIL filt_stream: cycle %0d got %0d expected %0d", k, filt_out, ew); end
      end
      if (k == 2 + NW + 2) begin
        vecs++;
        if (filt_out !== DW'(NW) || glb_rden !== 1'b0) begin
          errs++; $display("FAIL filt_hold: got filt %0d rden %b expected %0d 0", filt_out, glb_rden, NW);
        end
      end
      if (a_first != 0 && k < a_first + NA) begin
        ew = exp_a_q.size() ? exp_a_q.pop_front() : 'x;
        vecs++;
        if (act_out !== ew) begin errs++; $display("FAIL act_stream: cycle %0d got %0d expected %0d", k, act_out, ew); end
      end
      if (result_valid) begin
        e = exp_q.size() ? exp_q.pop_front() : 'x;
        vecs++;
        if ({result_idx, result_data} !== e) begin
          errs++; $display("FAIL result: got idx %0d data %0d expected idx %0d data %0d",
            result_idx, result_data, e[23:16], e[15:0]);
        end
      end
      if (pe_start) n_start++;
      if ($countones({load_en_wght, load_en_act, pe_start, result_valid, done}) > 1) n_ovl++;
      if (done) begin n_done++; fin = 1'b1; end
      @(negedge clk);
    end
    vecs++; if (!fin) begin errs++; $display("FAIL full_job_timeout: got no done expected done"); end
    vecs++; if (w_first != 2) begin errs++; $display("FAIL load_en_wght_cycle: got %0d expected 2", w_first); end
    vecs++; if (a_first != 15) begin errs++; $display("FAIL load_en_act_cycle: got %0d expected 15", a_first); end
    vecs++; if (n_lw != 1 || n_la != 1) begin errs++; $display("FAIL load_pulses: got %0d %0d expected 1 1", n_lw, n_la); end
    vecs++; if (n_start != NR + 1) begin errs++; $display("FAIL pe_start_count: got %0d expected %0d", n_start, NR + 1); end
    vecs++; if (n_done != 1) begin errs++; $display("FAIL done_count: got %0d expected 1", n_done); end
    vecs++; if (n_ovl != 0) begin errs++; $display("FAIL pulse_overlap: got %0d expected 0", n_ovl); end
    vecs++;
    if (exp_q.size() + exp_w_q.size() + exp_a_q.size() + exp_addr_q.size() != 0) begin
      errs++; $display("FAIL full_job_leftover: got %0d expected 0",
        exp_q.size() + exp_w_q.size() + exp_a_q.size() + exp_addr_q.size());
    end
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL after_done: got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  task automatic test_go_held();
    int n_rd = 0, n_start = 0, n_done = 0, n_busy_after = 0;
    bit fin = 1'b0;
    logic [23:0] e;
    push_results();
    go = 1'b1; @(negedge clk);
    for (int k = 1; k <= 400 && !fin; k++) begin
      if (glb_rden) n_rd++;
      if (pe_start) n_start++;
      if (result_valid) begin
        e = exp_q.size() ? exp_q.pop_front() : 'x;
        vecs++;
        if ({result_idx, result_data} !== e) begin
          errs++; $display("FAIL go_held_result: got idx %0d data %0d expected idx %0d data %0d",
            result_idx, result_data, e[23:16], e[15:0]);
        end
      end
      if (done) begin n_done++; fin = 1'b1; go = 1'b0; end
      @(negedge clk);
    end
    repeat (5) begin
      if (busy || glb_rden) n_busy_after++;
      @(negedge clk);
    end
    vecs++; if (n_rd != NW + NA) begin errs++; $display("FAIL go_held_reads: got %0d expected %0d", n_rd, NW + NA); end
    vecs++; if (n_start != NR + 1 || n_done != 1) begin
      errs++; $display("FAIL go_held_pulses: got start %0d done %0d expected %0d 1", n_start, n_done, NR + 1);
    end
    vecs++; if (n_busy_after != 0 || exp_q.size() != 0) begin
      errs++; $display("FAIL go_held_after: got busy cycles %0d left %0d expected 0 0", n_busy_after, exp_q.size());
    end
  endtask

  task automatic test_reset_midjob();
    int n_late = 0;
    bit seen = 1'b0, fin = 1'b0;
    logic [23:0] e;
    exp_q.delete();
    exp_q.push_back({8'd0, 16'd200});
    go = 1'b1; @(negedge clk); go = 1'b0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      if (result_valid) begin
        e = exp_q.size() ? exp_q.pop_front() : 'x;
        seen = 1'b1;
        vecs++;
        if ({result_idx, result_data} !== e) begin
          errs++; $display("FAIL midjob_result0: got idx %0d data %0d expected 0 200", result_idx, result_data);
        end
      end
      @(negedge clk);
    end
    vecs++; if (pe_start !== 1'b1) begin errs++; $display("FAIL midjob_restart: got pe_start %b expected 1", pe_start); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vecs++;
    if ({busy, done, glb_rden, load_en_wght, load_en_act, pe_start, result_valid} !== 7'b0 ||
        glb_raddr !== '0 || filt_out !== '0 || act_out !== '0 || result_data !== '0 || result_idx !== '0) begin
      errs++; $display("FAIL midjob_reset: got ctrl %b data %0d idx %0d filt %0d expected all 0",
        {busy, done, glb_rden, pe_start, result_valid}, result_data, result_idx, filt_out);
    end
    reset = 1'b0;
    repeat (12) begin
      if (result_valid || done || busy) n_late++;
      @(negedge clk);
    end
    vecs++; if (n_late != 0) begin errs++; $display("FAIL midjob_after_reset: got %0d active cycles expected 0", n_late); end
    push_results();
    go = 1'b1; @(negedge clk); go = 1'b0;
    for (int k = 1; k <= 400 && !fin; k++) begin
      if (result_valid) begin
        e = exp_q.size() ? exp_q.pop_front() : 'x;
        vecs++;
        if ({result_idx, result_data} !== e) begin
          errs++; $display("FAIL rerun_result: got idx %0d data %0d expected idx %0d data %0d",
            result_idx, result_data, e[23:16], e[15:0]);
        end
      end
      if (done) fin = 1'b1;
      @(negedge clk);
    end
    vecs++; if (!fin || exp_q.size() != 0) begin
      errs++; $display("FAIL rerun_complete: got done %b left %0d expected 1 0", fin, exp_q.size());
    end
  endtask

  task automatic test_spurious_load_done();
    int n_rd = 0, n_start = 0, n_done = 0, n_ovl = 0;
    bit fin = 1'b0;
    logic [23:0] e;
    push_results();
    go = 1'b1; @(negedge clk); go = 1'b0;
    for (int k = 1; k <= 400 && !fin; k++) begin
      if (glb_rden) n_rd++;
      if (pe_start) n_start++;
      if (result_valid) begin
        e = exp_q.size() ? exp_q.pop_front() : 'x;
        vecs++;
        if ({result_idx, result_data} !== e) begin
          errs++; $display("FAIL spurious_result: got idx %0d data %0d expected idx %0d data %0d",
            result_idx, result_data, e[23:16], e[15:0]);
        end
      end
      if ($countones({load_en_wght, load_en_act, pe_start, result_valid, done}) > 1) n_ovl++;
      if (done) begin n_done++; fin = 1'b1; end
      // A stray pulse lands in the following WAIT_C (after pe_start) or START (after a result).
      spur_ld = (pe_start && n_start <= NR) || result_valid;
      @(negedge clk);
    end
    spur_ld = 1'b0;
    vecs++; if (n_rd != NW + NA) begin errs++; $display("FAIL spurious_reads: got %0d expected %0d", n_rd, NW + NA); end
    vecs++; if (n_start != NR + 1 || n_done != 1 || n_ovl != 0) begin
      errs++; $display("FAIL spurious_pulses: got start %0d done %0d overlap %0d expected %0d 1 0",
        n_start, n_done, n_ovl, NR + 1);
    end
    vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL spurious_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < NW; i++) mem[WB + i] = DW'(i + 1);
    for (int i = 0; i < NA; i++) mem[AB + i] = DW'(101 + i);
    test_reset();
    test_full_job();
    test_go_held();
    test_reset_midjob();
    test_spurious_load_done();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter DATA_BITWIDTH, default 16, SHALL set the width of the data path.
REQ-002 Parameter GLB_ADDR_BITWIDTH, default 10, SHALL set the width of the global-buffer address.
REQ-003 Parameter W_BASE, default 0, SHALL be the global-buffer address of weight word 0.
REQ-004 Parameter A_BASE, default 16, SHALL be the global-buffer address of activation word 0.
REQ-005 Parameter kernel_size, default 3, SHALL give weight count NW = kernel_size*kernel_size.
REQ-006 Parameter act_size, default 5, SHALL give activation count NA = act_size*act_size and result count NR = act_size-kernel_size+1.
REQ-007 Ports (name, direction, width, meaning) SHALL be:
- clk in 1: single clock, all logic on posedge.
- reset in 1: synchronous, active-high.
- go in 1: one-cycle request to run one job.
- busy out 1: a job is in progress.
- done out 1: one-cycle pulse at job end.
- glb_rden out 1: global-buffer read enable.
- glb_raddr out GLB_ADDR_BITWIDTH: read address.
- glb_rdata in DATA_BITWIDTH: read data, valid exactly 1 cycle after glb_rden.
- filt_out out DATA_BITWIDTH: weight stream to PE.
- act_out out DATA_BITWIDTH: activation stream to PE.
- load_en_wght out 1: weight-load pulse to PE.
- load_en_act out 1: activation-load pulse to PE.
- pe_start out 1: compute-start pulse to PE.
- load_done in 1: PE load-complete pulse.
- compute_done in 1: PE row-complete pulse.
- pe_out in DATA_BITWIDTH: PE partial sum, valid while compute_done=1.
- result_valid out 1: result_data/result_idx valid for one cycle.
- result_data out DATA_BITWIDTH: captured partial sum.
- result_idx out 8: result index 0..NR-1.

Function
REQ-008 FSM states SHALL be IDLE, LOAD_W, WAIT_W, LOAD_A, WAIT_A, START, WAIT_C, REWIND, FIN.
REQ-009 IDLE with go=1 SHALL go to LOAD_W next cycle and set busy=1; go SHALL be ignored in all other states.
REQ-010 LOAD_W SHALL issue NW consecutive reads, glb_rden=1, addresses W_BASE..W_BASE+NW-1, one per cycle, first read in the first LOAD_W cycle.
REQ-011 Each returned word SHALL be driven on filt_out the cycle after its read; load_en_wght SHALL be 1 only in the cycle word 0 is on filt_out.
REQ-012 After the last word, filt_out SHALL hold that word, glb_rden=0, and state SHALL be WAIT_W until load_done=1, then LOAD_A.
REQ-013 LOAD_A/WAIT_A SHALL mirror REQ-010..012 using A_BASE, NA words, act_out, load_en_act; load_done in WAIT_A SHALL advance to START.
REQ-014 load_done SHALL be honoured only in WAIT_W/WAIT_A and ignored elsewhere.
REQ-015 START SHALL drive pe_start=1 for exactly one cycle, then go to WAIT_C.
REQ-016 In WAIT_C, a cycle with compute_done=1 SHALL capture pe_out; the next cycle SHALL have result_valid=1, result_data=captured value, result_idx=row counter; the row counter SHALL then increment.
REQ-017 After capture, if rows captured < NR the state SHALL return to START, else go to REWIND.
REQ-018 REWIND SHALL drive one pe_start pulse, returning the PE row counter to 0, and SHALL capture no result; then FIN.
REQ-019 FIN SHALL pulse done=1 for one cycle, clear busy, reset the row counter to 0, and return to IDLE; go in the FIN cycle SHALL be ignored.
REQ-020 Latency from go: glb_rden=1 at cycle +1, load_en_wght=1 at cycle +2.
REQ-021 Address generation SHALL be modulo 2^GLB_ADDR_BITWIDTH; word counters SHALL be 16 bits, row counter 8 bits.
REQ-022 load_en_wght, load_en_act, pe_start, result_valid, done SHALL never be 1 in the same cycle as each other.

Reset
REQ-023 reset=1 SHALL force IDLE and zero all counters and outputs (busy, done, glb_rden, glb_raddr, filt_out, act_out, load_en_*, pe_start, result_*) on the next edge.
REQ-024 reset SHALL take priority over go and all PE inputs, including mid-job; no result or done SHALL follow a mid-job reset.

Verification
REQ-025 K=3, A=5, GLB words W_BASE+i=i+1, A_BASE+i=101+i, go at cycle 0 -> glb_rden cycle 1; filt_out 1..9 cycles 2..10; load_en_wght only cycle 2.
REQ-026 PE stub pulses load_done 3 cycles after last word; then act_out 101..125 over 25 cycles, load_en_act only with 101.
REQ-027 Stub: compute_done 5 cycles after each pe_start, pe_out=200+row -> results 200,201,202 with idx 0,1,2; then exactly one extra pe_start; done 1 cycle; 4 pe_start pulses total.
REQ-028 go held high throughout the job -> exactly one job, no restart until IDLE.
REQ-029 reset asserted in WAIT_C after result 0 -> all outputs 0 next cycle; a following go runs a full job with idx starting at 0.
REQ-030 Spurious load_done during START/WAIT_C -> ignored; state and outputs unchanged.
